// File: rtl/output_sync_arbiter.sv
// rtl/output_sync_arbiter.sv - rising-edge capture of ready peripheral words into one-entry slots, arbitrated onto a registered output
module output_sync_arbiter #(
    parameter int         NUM_PERIPH = 4,
    parameter int         DATA_W     = 16,
    parameter int         TASK_W     = 8,
    parameter int         STAT_LSB   = 8,
    parameter logic [3:0] READY_CODE = 4'h1,
    parameter bit         RR_MODE    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [TASK_W-1:0]            next_task,
    input  logic                         task_valid,
    input  logic [NUM_PERIPH*DATA_W-1:0] periph,
    output logic [DATA_W-1:0]            out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0]                   out_src,
    output logic [NUM_PERIPH-1:0]        drop_flag,
    input  logic                         drop_clr
);

    localparam int IDX_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

    logic [NUM_PERIPH-1:0] prev_match_q, prev_match_d;
    logic [NUM_PERIPH-1:0] slot_full_q, slot_full_d;
    logic [DATA_W-1:0]     slot_data_q [NUM_PERIPH];
    logic [DATA_W-1:0]     slot_data_d [NUM_PERIPH];
    logic [NUM_PERIPH-1:0] drop_flag_q, drop_flag_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]     out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic [3:0]            out_src_q, out_src_d;

    logic [NUM_PERIPH-1:0] match;
    logic [NUM_PERIPH-1:0] rise;
    logic [NUM_PERIPH-1:0] grant_vec;
    logic [NUM_PERIPH-1:0] drop;
    logic                  loadable;
    logic                  grant_any;
    logic                  grant;
    logic [IDX_W-1:0]      grant_sel;

    always_comb begin
        for (int i = 0; i < NUM_PERIPH; i++) begin
            match[i] = (periph[i*DATA_W+STAT_LSB +: 4] == READY_CODE);
        end
        rise     = match & ~prev_match_q;
        loadable = ~out_valid_q | out_ready;

        // Scan starts just after the last winner in round-robin mode, at 0 otherwise.
        grant_any = 1'b0;
        grant_sel = '0;
        for (int k = 0; k < NUM_PERIPH; k++) begin
            int idx;
            idx = RR_MODE ? ((int'(rr_ptr_q) + 1 + k) % NUM_PERIPH) : k;
            if (!grant_any && slot_full_q[idx]) begin
                grant_any = 1'b1;
                grant_sel = IDX_W'(idx);
            end
        end
        grant = loadable & grant_any;

        for (int i = 0; i < NUM_PERIPH; i++) begin
            grant_vec[i]   = grant && (grant_sel == IDX_W'(i));
            slot_full_d[i] = (slot_full_q[i] & ~grant_vec[i]) | rise[i];
            drop[i]        = rise[i] & slot_full_q[i] & ~grant_vec[i];
            slot_data_d[i] = slot_data_q[i];
            if (rise[i] && (!slot_full_q[i] || grant_vec[i])) begin
                slot_data_d[i] = periph[i*DATA_W +: DATA_W];
            end
        end

        // A drop in the same cycle as a clear wins, so the event is never lost.
        drop_flag_d  = (drop_clr ? '0 : drop_flag_q) | drop;
        prev_match_d = match;

        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant) begin
            out_d       = slot_data_q[grant_sel];
            out_valid_d = 1'b1;
            out_src_d   = 4'(grant_sel);
            if (RR_MODE) begin
                rr_ptr_d = grant_sel;
            end
        end else if (loadable && task_valid) begin
            out_d       = DATA_W'(next_task);
            out_valid_d = 1'b1;
            out_src_d   = 4'hF;
        end else if (loadable) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_match_q <= '0;
            slot_full_q  <= '0;
            for (int i = 0; i < NUM_PERIPH; i++) begin
                slot_data_q[i] <= '0;
            end
            drop_flag_q  <= '0;
            rr_ptr_q     <= IDX_W'(NUM_PERIPH - 1);
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            out_src_q    <= 4'hF;
        end else begin
            prev_match_q <= prev_match_d;
            slot_full_q  <= slot_full_d;
            for (int i = 0; i < NUM_PERIPH; i++) begin
                slot_data_q[i] <= slot_data_d[i];
            end
            drop_flag_q  <= drop_flag_d;
            rr_ptr_q     <= rr_ptr_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            out_src_q    <= out_src_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign drop_flag = drop_flag_q;

endmodule

// File: tb/tb_output_sync_arbiter.sv
// tb/tb_output_sync_arbiter.sv - round-robin and fixed-priority instances checked against a behavioural model
module tb_output_sync_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  next_task;
    logic        task_valid;
    logic [63:0] periph;
    logic        out_ready;
    logic        drop_clr;

    logic [15:0] dut_out  [2];
    logic        dut_ov   [2];
    logic [3:0]  dut_src  [2];
    logic [3:0]  dut_drop [2];

    always #5 clk = ~clk;

    output_sync_arbiter #(.RR_MODE(1'b1)) u_dut_rr (
        .clk(clk), .rst_n(rst_n), .next_task(next_task), .task_valid(task_valid),
        .periph(periph), .out(dut_out[0]), .out_valid(dut_ov[0]), .out_ready(out_ready),
        .out_src(dut_src[0]), .drop_flag(dut_drop[0]), .drop_clr(drop_clr)
    );

    output_sync_arbiter #(.RR_MODE(1'b0)) u_dut_fp (
        .clk(clk), .rst_n(rst_n), .next_task(next_task), .task_valid(task_valid),
        .periph(periph), .out(dut_out[1]), .out_valid(dut_ov[1]), .out_ready(out_ready),
        .out_src(dut_src[1]), .drop_flag(dut_drop[1]), .drop_clr(drop_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model state; index [0] is the round-robin instance, [1] fixed priority.
    bit          m_full [2][4];
    logic [15:0] m_data [2][4];
    bit          m_prev [4];
    int          m_last [2];
    logic [15:0] m_out  [2];
    bit          m_ov   [2];
    logic [3:0]  m_src  [2];
    logic [3:0]  m_drop [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                m_full[m][i] = 0;
                m_data[m][i] = '0;
            end
            m_last[m] = 3;
            m_out[m]  = '0;
            m_ov[m]   = 0;
            m_src[m]  = 4'hF;
            m_drop[m] = '0;
        end
        for (int i = 0; i < 4; i++) m_prev[i] = 0;
    endtask

    task automatic model_step();
        bit          ready_now [4];
        logic [15:0] word      [4];
        for (int i = 0; i < 4; i++) begin
            word[i]      = periph[i*16 +: 16];
            ready_now[i] = (word[i][11:8] == 4'h1);
        end
        for (int m = 0; m < 2; m++) begin
            bit loadable;
            int winner;
            loadable = !m_ov[m] || out_ready;
            winner   = -1;
            if (loadable) begin
                for (int k = 0; k < 4; k++) begin
                    int c;
                    c = (m == 0) ? (m_last[m] + 1 + k) % 4 : k;
                    if (winner < 0 && m_full[m][c]) winner = c;
                end
            end
            if (winner >= 0) begin
                m_out[m]          = m_data[m][winner];
                m_src[m]          = 4'(winner);
                m_ov[m]           = 1;
                m_full[m][winner] = 0;
                m_last[m]         = winner;
            end else if (loadable && task_valid) begin
                m_out[m] = {8'h00, next_task};
                m_src[m] = 4'hF;
                m_ov[m]  = 1;
            end else if (loadable) begin
                m_ov[m] = 0;
            end
            if (drop_clr) m_drop[m] = '0;
            for (int i = 0; i < 4; i++) begin
                if (ready_now[i] && !m_prev[i]) begin
                    if (m_full[m][i]) begin
                        m_drop[m][i] = 1'b1;
                    end else begin
                        m_full[m][i] = 1;
                        m_data[m][i] = word[i];
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) m_prev[i] = ready_now[i];
    endtask

    task automatic compare_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s m%0d out_valid", tag, m), 32'(dut_ov[m]), 32'(m_ov[m]));
            chk($sformatf("%s m%0d out", tag, m), 32'(dut_out[m]), 32'(m_out[m]));
            chk($sformatf("%s m%0d out_src", tag, m), 32'(dut_src[m]), 32'(m_src[m]));
            chk($sformatf("%s m%0d drop_flag", tag, m), 32'(dut_drop[m]), 32'(m_drop[m]));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    function automatic logic [15:0] mkword(input bit rdy);
        logic [15:0] w;
        logic [3:0]  s;
        w = 16'($urandom);
        s = 4'($urandom_range(0, 15));
        if (s == 4'h1) s = 4'h0;
        w[11:8] = rdy ? 4'h1 : s;
        return w;
    endfunction

    bit cur_rdy [4];
    int emitted;

    initial begin
        rst_n      = 1'b0;
        periph     = '0;
        task_valid = 1'b0;
        next_task  = '0;
        out_ready  = 1'b1;
        drop_clr   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", 32'(dut_out[0]), 32'h0);
        chk("reset out_valid", 32'(dut_ov[0]), 32'h0);
        chk("reset out_src", 32'(dut_src[0]), 32'hF);
        chk("reset drop_flag", 32'(dut_drop[1]), 32'h0);
        rst_n = 1'b1;

        // Single word held ready for ten cycles is emitted once, two edges after the match.
        periph[31:16] = 16'h0123;
        step("single");
        chk("single early out_valid", 32'(dut_ov[0]), 32'h0);
        step("single");
        chk("single out", 32'(dut_out[0]), 32'h0123);
        chk("single out_src", 32'(dut_src[0]), 32'h1);
        emitted = 1;
        for (int c = 0; c < 8; c++) begin
            step("single");
            emitted += int'(dut_ov[0]);
        end
        chk("single emit count", 32'(emitted), 32'h1);
        periph = '0;
        step("idle");

        // Fallback task, then a peripheral word displaces it.
        task_valid = 1'b1;
        next_task  = 8'h2B;
        step("task");
        chk("task out", 32'(dut_out[0]), 32'h002B);
        chk("task out_src", 32'(dut_src[0]), 32'hF);
        periph[47:32] = 16'h0155;
        step("task");
        step("task");
        chk("periph over task out", 32'(dut_out[0]), 32'h0155);
        chk("periph over task src", 32'(dut_src[0]), 32'h2);
        task_valid = 1'b0;
        periph     = '0;
        step("idle");
        step("idle");

        // Channel 3 overflow while the consumer stalls.
        out_ready     = 1'b0;
        periph[63:48] = 16'h0133;
        step("drop");
        step("drop");
        periph[63:48] = 16'h0000;
        step("drop");
        periph[63:48] = 16'h0144;
        step("drop");
        periph[63:48] = 16'h0000;
        step("drop");
        periph[63:48] = 16'h0155;
        step("drop");
        chk("drop flag set", 32'(dut_drop[0]), 32'h8);
        chk("drop first word held", 32'(dut_out[0]), 32'h0133);
        out_ready = 1'b1;
        periph    = '0;
        step("drop");
        chk("drop second word out", 32'(dut_out[0]), 32'h0144);
        drop_clr = 1'b1;
        step("drop");
        drop_clr = 1'b0;
        chk("drop flag cleared", 32'(dut_drop[0]), 32'h0);

        // Randomized traffic with independently toggling ready status per channel.
        for (int i = 0; i < 4; i++) cur_rdy[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) cur_rdy[i] = !cur_rdy[i];
                periph[i*16 +: 16] = mkword(cur_rdy[i]);
            end
            task_valid = ($urandom_range(0, 3) == 0);
            next_task  = 8'($urandom);
            out_ready  = ($urandom_range(0, 2) != 0);
            drop_clr   = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        // Reset in the middle of a transfer discards everything.
        periph     = '0;
        task_valid = 1'b0;
        drop_clr   = 1'b0;
        out_ready  = 1'b1;
        repeat (6) step("drain");
        out_ready = 1'b0;
        periph    = {16'h01A3, 16'h01A2, 16'h01A1, 16'h01A0};
        step("midreset");
        step("midreset");
        chk("pre-reset out_valid", 32'(dut_ov[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async reset out", 32'(dut_out[0]), 32'h0);
        chk("async reset out_valid", 32'(dut_ov[0]), 32'h0);
        chk("async reset out_src", 32'(dut_src[0]), 32'hF);
        chk("async reset fp out_valid", 32'(dut_ov[1]), 32'h0);
        @(posedge clk);
        #1;
        periph    = '0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        emitted   = 0;
        for (int c = 0; c < 4; c++) begin
            step("postreset");
            emitted += int'(dut_ov[0]) + int'(dut_ov[1]);
        end
        chk("no stale word after reset", 32'(emitted), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_sync_arbiter.md
OUTPUT_SYNC_ARBITER -- requirements
Module: output_sync_arbiter

Interface
REQ-001 SHALL have parameter NUM_PERIPH, default 4, meaning number of peripheral input channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 16, meaning peripheral and output word width.
REQ-003 SHALL have parameter TASK_W, default 8, meaning next_task width (TASK_W <= DATA_W).
REQ-004 SHALL have parameter STAT_LSB, default 8, meaning LSB of the 4-bit status field inside a peripheral word.
REQ-005 SHALL have parameter READY_CODE, default 4'h1, meaning status field value that marks a word as ready.
REQ-006 SHALL have parameter RR_MODE, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with channel 0 highest.
REQ-007 clk  input  1  system clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  reset, asynchronous and active-low.
REQ-009 next_task  input  TASK_W  fallback task identifier (Op [5:3], Task id [2:0]).
REQ-010 task_valid  input  1  next_task is presentable.
REQ-011 periph  input  NUM_PERIPH*DATA_W  concatenated peripheral words; channel i is bits [i*DATA_W +: DATA_W].
REQ-012 out  output  DATA_W  registered output word.
REQ-013 out_valid  output  1  out holds a word not yet accepted.
REQ-014 out_ready  input  1  consumer accepts out this cycle when out_valid=1.
REQ-015 out_src  output  4  source of out: channel index 0..NUM_PERIPH-1, or 4'hF for next_task.
REQ-016 drop_flag  output  NUM_PERIPH  sticky per-channel overflow indicator.
REQ-017 drop_clr  input  1  synchronous clear of drop_flag.

Function
REQ-018 Channel i SHALL match when periph word i bits [STAT_LSB+3:STAT_LSB] equal READY_CODE.
REQ-019 Capture SHALL occur on a rising match only (match now, no match in the previous cycle); a word held ready for many cycles is captured once.
REQ-020 On capture, the word SHALL be stored in channel i's one-entry pending slot, which is marked full.
REQ-021 A capture into a full slot SHALL be discarded and SHALL set drop_flag[i]; the slot contents are unchanged.
REQ-022 Output register SHALL be loadable when out_valid=0 or (out_valid=1 and out_ready=1) in the same cycle.
REQ-023 When loadable and any slot is full, the SHALL grant exactly one slot, load its word into out, set out_src to its index, and mark it empty, all in the same edge.
REQ-024 RR_MODE=1: search SHALL start at (last granted index + 1) mod NUM_PERIPH; pointer initial value after reset SHALL be NUM_PERIPH-1 so channel 0 is searched first.
REQ-025 RR_MODE=0: lowest full index SHALL win; pointer unused.
REQ-026 When loadable, no slot full and task_valid=1, out SHALL load next_task zero-extended to DATA_W with out_src=4'hF.
REQ-027 When loadable and nothing to load, out_valid SHALL drop to 0; out and out_src hold their value.
REQ-028 A slot granted and captured in the same cycle SHALL end full with the new word (grant reads old word; no drop).
REQ-029 Latency SHALL be: rising match at edge N -> slot full after edge N -> out_valid with that word after edge N+1 at the earliest.
REQ-030 While out_valid=1 and out_ready=0, out, out_src SHALL be stable.
REQ-031 drop_clr=1 SHALL clear drop_flag; a drop in the same cycle SHALL take priority (flag stays set).
REQ-032 Peripheral channels SHALL always take precedence over next_task.

Reset
REQ-033 While rst_n=0: out=0, out_valid=0, out_src=4'hF, drop_flag=0, all slots empty, previous-match history cleared, RR pointer=NUM_PERIPH-1.
REQ-034 A word matching on the first edge after reset release SHALL count as a rising match.
REQ-035 Reset asserted mid-transfer SHALL discard pending and output words without emission.

Verification
REQ-036 Default params, periph1=16'h0123 held 10 cycles, out_ready=1 -> exactly one out=16'h0123, out_src=1, 2 cycles after match.
REQ-037 Channels 0..3 all rise with 16'h01A0..16'h01A3 same cycle, RR_MODE=1, out_ready=1 -> outputs in order src 0,1,2,3 on consecutive cycles.
REQ-038 Same stimulus, RR_MODE=0, out_ready=0 for 5 cycles then 1 -> out=16'h01A0 stable 5 cycles, then src 1,2,3.
REQ-039 No match, task_valid=1, next_task=8'h2B -> out=16'h002B, out_src=4'hF; periph2 then rises with 16'h0155 -> next load is 16'h0155, src 2.
REQ-040 Channel 3 rises, falls, rises again while slot full and out_ready=0 -> drop_flag=4'b1000, first word still emitted; drop_clr -> drop_flag=0.
REQ-041 rst_n pulsed low with two full slots and out_valid=1 -> all outputs at reset values immediately, no stale word after release.
